mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Initiator for the team's synchronous single-port memory/CSR slave bus (wr/addr/wdata/rdata/response).
- Accepts one command at a time on a valid/ready request port and sequences the bus.
- Captures read data one cycle after the address phase and waits, with a timeout, for the write-acknowledge pulse.
- After reset, optionally enables the slave by writing CHIP_EN itself before accepting any user command.

Parameters:
ADDR_W, 8, bus/request address width
DATA_W, 32, bus/request data width
MEM_DEPTH, 16, addresses 0..MEM_DEPTH-1 are memory (write-acknowledged); all others are CSRs (no acknowledge)
CHIP_EN_ADDR, 8'h20, CSR address of the chip-enable register
STAT_ADDR, 8'h18, side-effect-free CSR address parked on the bus while idle
RSP_TIMEOUT, 4, cycles to wait for bus_response before flagging an error
INIT_EN, 1, 1 = issue CHIP_EN=1 write automatically after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  command present
req_ready  out  1  master can accept a command
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  target address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  qualified by rsp_valid: timeout or read while disabled
bus_wr  out  1  slave write strobe
bus_addr  out  ADDR_W  slave address
bus_wdata  out  DATA_W  slave write data
bus_rdata  in  DATA_W  slave read data (registered in slave)
bus_response  in  1  slave write acknowledge
chip_en  out  1  shadow of CHIP_EN bit 0 as last written
timeout_cnt  out  8  saturating count of write timeouts

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, bus_wr=0, bus_addr=STAT_ADDR, bus_wdata=0, chip_en=0, timeout_cnt=0. Reset is asynchronous; an assertion mid-operation aborts the command with no rsp_valid, and the FSM restarts from INIT (or IDLE when INIT_EN=0).
- All outputs are registered.
- States:
  - INIT: bus_wr=1, bus_addr=CHIP_EN_ADDR, bus_wdata=1 for one cycle; set chip_en=1 -> IDLE. INIT is skipped when INIT_EN=0.
  - IDLE: req_ready=1, bus_wr=0, bus_addr=STAT_ADDR. On req_valid&&req_ready, latch the command -> WRITE or READ. A read while chip_en=0 is not issued on the bus: the next cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0, then the FSM returns to IDLE.
  - WRITE: bus_wr=1 for exactly one cycle with the latched addr/wdata.
    - addr<MEM_DEPTH -> WAIT_RSP.
    - Otherwise -> DONE with err=0 (CSR writes are never acknowledged).
    - A write to CHIP_EN_ADDR updates chip_en=wdata[0].
  - WAIT_RSP: bus_wr=0, timer counts from 1. bus_response sampled 1 -> DONE, err=0. If the timer reaches RSP_TIMEOUT with no response -> DONE, err=1, timeout_cnt++ (saturates at 255).
  - READ: bus_wr=0, bus_addr=latched addr for one cycle -> READ_CAP.
  - READ_CAP: bus_rdata is valid this cycle; capture it into rsp_rdata -> DONE, err=0.
  - DONE: rsp_valid=1 for one cycle; req_ready=0 -> IDLE.
- Latencies from the accept edge to rsp_valid high:
  - read: 3 cycles
  - CSR write: 2 cycles
  - acknowledged memory write: 3 cycles minimum; timeout at RSP_TIMEOUT+2.
- Back-to-back: req_ready is low from accept until the cycle after DONE, so at most one command is outstanding.
- bus_response arriving outside WAIT_RSP is ignored.
- A memory write accepted while chip_en=0 is still issued. The slave drops it, so the command times out with err=1.
- Address wrap: none. req_addr is passed through unmodified; its width is ADDR_W.

Decomposition:
- Shared package mem_bus_pkg: state enum typedef (INIT, IDLE, WRITE, WAIT_RSP, READ, READ_CAP, DONE) and address constants (CHIP_EN_ADDR 8'h20, STAT_ADDR 8'h18, CSR3_ADDR 8'h24, WR_COUNT_ADDR 8'h18).
- One sub-module, mem_bus_timeout: loadable down-counter with an expire flag, reused for the WAIT_RSP timer.

Test Plan:
- Reset with INIT_EN=1 -> one bus_wr pulse, addr 8'h20, wdata 1; chip_en=1; req_ready high on the following cycle.
- Write addr 3, data 32'hDEADBEEF, slave acknowledges -> rsp_valid 3 cycles after accept, rsp_err=0. Then read addr 3 -> rsp_rdata=32'hDEADBEEF, 3-cycle latency.
- Write CSR 8'h24 = 32'h12345678, then read it back -> write completes in 2 cycles with err=0; read returns 32'h12345678.
- Write addr 5 with the slave acknowledge forced low -> rsp_err=1 at RSP_TIMEOUT+2 cycles; timeout_cnt=1.
- Write 8'h20 = 0, then read addr 2 -> chip_en=0; read returns rsp_err=1, rsp_rdata=0, and no bus read address phase occurs.
- Assert reset during WAIT_RSP -> no rsp_valid; outputs at reset values; the INIT write repeats after reset is released.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and address map for the memory/CSR bus initiator.
// Holds the master FSM state enum and the slave's fixed CSR addresses.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        WAIT_RSP,
        READ,
        READ_CAP,
        DONE
    } state_t;

    localparam logic [7:0] CHIP_EN_ADDR  = 8'h20;
    localparam logic [7:0] STAT_ADDR     = 8'h18;
    localparam logic [7:0] CSR3_ADDR     = 8'h24;
    localparam logic [7:0] WR_COUNT_ADDR = 8'h18;

endpackage

// File: rtl/mem_bus_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Ports: clk, reset, load/load_val (preset), en (count down), expired.
module mem_bus_timeout
    import mem_bus_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Single-command initiator for the memory/CSR slave bus.
// Ports: req_* command in, rsp_* completion out, bus_* slave side,
// chip_en shadow of CHIP_EN bit 0, timeout_cnt saturating error count.
module mem_bus_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 16,
    parameter logic [ADDR_W-1:0] CHIP_EN_ADDR =
        ADDR_W'(mem_bus_pkg::CHIP_EN_ADDR),
    parameter logic [ADDR_W-1:0] STAT_ADDR =
        ADDR_W'(mem_bus_pkg::STAT_ADDR),
    parameter int RSP_TIMEOUT = 4,
    parameter bit INIT_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_response,
    output logic              chip_en,
    output logic [7:0]        timeout_cnt
);

    import mem_bus_pkg::*;

    localparam int TW = 8;
    localparam logic [ADDR_W-1:0] MEM_TOP = ADDR_W'(MEM_DEPTH);
    localparam logic [TW-1:0] TMO_LOAD = TW'(RSP_TIMEOUT - 1);

    state_t state;
    logic   expired;

    // bus_addr/bus_wdata double as the latched command while in flight.
    mem_bus_timeout #(.W(TW)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .load     (state == WRITE),
        .load_val (TMO_LOAD),
        .en       (state == WAIT_RSP),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT_EN ? INIT : IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            bus_wr      <= 1'b0;
            bus_addr    <= STAT_ADDR;
            bus_wdata   <= '0;
            chip_en     <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                INIT: begin
                    bus_wr    <= 1'b1;
                    bus_addr  <= CHIP_EN_ADDR;
                    bus_wdata <= DATA_W'(1);
                    chip_en   <= 1'b1;
                    state     <= IDLE;
                end
                IDLE: begin
                    bus_wr    <= 1'b0;
                    bus_addr  <= STAT_ADDR;
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (req_wr) begin
                            bus_wr    <= 1'b1;
                            bus_addr  <= req_addr;
                            bus_wdata <= req_wdata;
                            state     <= WRITE;
                        end else if (chip_en) begin
                            bus_addr <= req_addr;
                            state    <= READ;
                        end else begin
                            // disabled read never reaches the bus
                            rsp_err <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                WRITE: begin
                    bus_wr <= 1'b0;
                    if (bus_addr == CHIP_EN_ADDR)
                        chip_en <= bus_wdata[0];
                    if (bus_addr < MEM_TOP)
                        state <= WAIT_RSP;
                    else
                        state <= DONE;
                end
                WAIT_RSP: begin
                    if (bus_response) begin
                        state <= DONE;
                    end else if (expired) begin
                        rsp_err <= 1'b1;
                        if (timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 8'd1;
                        state <= DONE;
                    end
                end
                READ: begin
                    state <= READ_CAP;
                end
                READ_CAP: begin
                    rsp_rdata <= bus_rdata;
                    state     <= DONE;
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    bus_addr  <= STAT_ADDR;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a small behavioural slave.
// Checks reset/init, read/write latencies, timeout and chip-disable paths.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_wr;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_response;
    logic        chip_en;
    logic [7:0]  timeout_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_master dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .bus_wr       (bus_wr),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_response (bus_response),
        .chip_en      (chip_en),
        .timeout_cnt  (timeout_cnt)
    );

    // behavioural slave: registered read data, ack pulse on memory writes
    logic [31:0] smem [16];
    logic        s_en;
    logic [31:0] s_csr3;
    logic        nack = 1'b0;

    initial for (int i = 0; i < 16; i++) smem[i] = '0;

    function automatic logic [31:0] s_read(input logic [7:0] a);
        if (a < 8'd16) return smem[a[3:0]];
        if (a == 8'h20) return {31'b0, s_en};
        if (a == 8'h24) return s_csr3;
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_en         <= 1'b0;
            s_csr3       <= '0;
            bus_response <= 1'b0;
            bus_rdata    <= '0;
        end else begin
            bus_response <= 1'b0;
            bus_rdata    <= s_read(bus_addr);
            if (bus_wr) begin
                if (bus_addr == 8'h20) begin
                    s_en <= bus_wdata[0];
                end else if (s_en) begin
                    if (bus_addr < 8'd16) begin
                        smem[bus_addr[3:0]] <= bus_wdata;
                        bus_response <= !nack;
                    end else if (bus_addr == 8'h24) begin
                        s_csr3 <= bus_wdata;
                    end
                end
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // issue one command; lat = cycles from accept edge to rsp_valid
    task automatic issue(input logic wr, input logic [7:0] a,
                         input logic [31:0] d, output int lat,
                         output logic [31:0] rd, output logic err,
                         output logic saw_addr);
        int w;
        lat = 0;
        rd = 'x;
        err = 1'bx;
        saw_addr = 1'b0;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (!bus_wr && bus_addr == a) saw_addr = 1'b1;
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = n;
                rd  = rsp_rdata;
                err = rsp_err;
                break;
            end
        end
    endtask

    task automatic init_seq(input string p);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check({p, "_init_wr"}, 32'(bus_wr), 32'd1);
        check({p, "_init_addr"}, 32'(bus_addr), 32'h20);
        check({p, "_init_data"}, bus_wdata, 32'd1);
        check({p, "_init_en"}, 32'(chip_en), 32'd1);
        @(posedge clk);
        #1;
        check({p, "_init_wr_off"}, 32'(bus_wr), 32'd0);
        check({p, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic reset_vals(input string p);
        check({p, "_rst_ready"}, 32'(req_ready), 32'd0);
        check({p, "_rst_valid"}, 32'(rsp_valid), 32'd0);
        check({p, "_rst_rdata"}, rsp_rdata, 32'd0);
        check({p, "_rst_err"}, 32'(rsp_err), 32'd0);
        check({p, "_rst_bwr"}, 32'(bus_wr), 32'd0);
        check({p, "_rst_baddr"}, 32'(bus_addr), 32'h18);
        check({p, "_rst_bwdata"}, bus_wdata, 32'd0);
        check({p, "_rst_en"}, 32'(chip_en), 32'd0);
        check({p, "_rst_tmo"}, 32'(timeout_cnt), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;
        logic        saw;
        int          spur;

        #12;
        reset_vals("por");
        init_seq("por");

        issue(1'b1, 8'd3, 32'hDEADBEEF, lat, rd, err, saw);
        check("mwr_lat", 32'(lat), 32'd3);
        check("mwr_err", 32'(err), 32'd0);
        issue(1'b0, 8'd3, 32'd0, lat, rd, err, saw);
        check("mrd_lat", 32'(lat), 32'd3);
        check("mrd_data", rd, 32'hDEADBEEF);
        check("mrd_err", 32'(err), 32'd0);

        issue(1'b1, 8'h24, 32'h12345678, lat, rd, err, saw);
        check("cwr_lat", 32'(lat), 32'd2);
        check("cwr_err", 32'(err), 32'd0);
        check("cwr_rdata", rd, 32'd0);
        issue(1'b0, 8'h24, 32'd0, lat, rd, err, saw);
        check("crd_lat", 32'(lat), 32'd3);
        check("crd_data", rd, 32'h12345678);

        nack = 1'b1;
        issue(1'b1, 8'd5, 32'hA5A5A5A5, lat, rd, err, saw);
        nack = 1'b0;
        check("tmo_lat", 32'(lat), 32'd6);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_cnt", 32'(timeout_cnt), 32'd1);

        issue(1'b1, 8'h20, 32'd0, lat, rd, err, saw);
        check("dis_lat", 32'(lat), 32'd2);
        check("dis_en", 32'(chip_en), 32'd0);
        issue(1'b0, 8'd2, 32'd0, lat, rd, err, saw);
        check("drd_lat", 32'(lat), 32'd1);
        check("drd_err", 32'(err), 32'd1);
        check("drd_data", rd, 32'd0);
        check("drd_noaddr", 32'(saw), 32'd0);

        // write while disabled reaches WAIT_RSP, then reset aborts it
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'd5;
        req_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset_vals("mid");
        spur = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) spur++;
        end
        init_seq("mid");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) spur++;
        end
        check("mid_no_rsp", 32'(spur), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
